// File: rtl/tcb_net_pkg.sv
// Shared definitions for the MNIST TCB net back end.
// Holds class count, score width, class-index width, the signed score
// type and the state encoding of the argmax scanner.
package tcb_net_pkg;

    localparam int N_CLASS = 10;
    localparam int SCORE_W = 28;
    localparam int IDX_W   = 4;

    typedef logic signed [SCORE_W-1:0] score_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/signed_max_cmp.sv
// Combinational signed "greater-than" step of a running argmax.
// Ports:
//   cand_i / cand_idx_i : candidate score and its index
//   cur_max_i / cur_idx_i : running maximum and its index
//   nxt_max_o / nxt_idx_o : running maximum after this candidate
// Ties keep the running value, so the lower index wins when candidates
// are presented in increasing index order.
module signed_max_cmp #(
    parameter int DATA_WIDTH = 28,
    parameter int IDX_WIDTH  = 4
) (
    input  logic [DATA_WIDTH-1:0] cand_i,
    input  logic [IDX_WIDTH-1:0]  cand_idx_i,
    input  logic [DATA_WIDTH-1:0] cur_max_i,
    input  logic [IDX_WIDTH-1:0]  cur_idx_i,
    output logic [DATA_WIDTH-1:0] nxt_max_o,
    output logic [IDX_WIDTH-1:0]  nxt_idx_o
);

    logic take_cand;

    assign take_cand = $signed(cand_i) > $signed(cur_max_i);
    assign nxt_max_o = take_cand ? cand_i     : cur_max_i;
    assign nxt_idx_o = take_cand ? cand_idx_i : cur_idx_i;

endmodule

// File: rtl/layer2_argmax_10x28.sv
// Serial argmax over the N packed signed class scores of the output layer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   valid      : layer_in holds a score vector this cycle
//   layer_in   : N packed scores, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ready      : one-cycle pulse, class_out/max_out carry a new result
//   class_out  : index of the maximum score (held)
//   max_out    : maximum score (held)
//   busy       : scan in progress
//   drop       : one-cycle pulse, a valid arrived while busy and was ignored
// The vector is captured into a local bank on the accepting edge, then one
// element per cycle is compared against the running maximum.
module layer2_argmax_10x28
    import tcb_net_pkg::*;
#(
    parameter int N          = N_CLASS,
    parameter int DATA_WIDTH = SCORE_W,
    parameter int IDX_WIDTH  = IDX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic [N*DATA_WIDTH-1:0] layer_in,
    output logic                    ready,
    output logic [IDX_WIDTH-1:0]    class_out,
    output logic [DATA_WIDTH-1:0]   max_out,
    output logic                    busy,
    output logic                    drop
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);

    logic [DATA_WIDTH-1:0] in_elem [N];
    logic [DATA_WIDTH-1:0] bank_q  [N];

    state_e                state_q,   state_d;
    logic [IDX_WIDTH-1:0]  cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] cur_max_q, cur_max_d;
    logic [IDX_WIDTH-1:0]  cur_idx_q, cur_idx_d;
    logic [IDX_WIDTH-1:0]  class_q,   class_d;
    logic [DATA_WIDTH-1:0] max_q,     max_d;
    logic                  ready_q,   ready_d;
    logic                  drop_q,    drop_d;
    logic                  load_bank;

    logic [DATA_WIDTH-1:0] nxt_max;
    logic [IDX_WIDTH-1:0]  nxt_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign in_elem[gi] = layer_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    signed_max_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_cmp (
        .cand_i     (bank_q[cnt_q]),
        .cand_idx_i (cnt_q),
        .cur_max_i  (cur_max_q),
        .cur_idx_i  (cur_idx_q),
        .nxt_max_o  (nxt_max),
        .nxt_idx_o  (nxt_idx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_max_d = cur_max_q;
        cur_idx_d = cur_idx_q;
        class_d   = class_q;
        max_d     = max_q;
        ready_d   = 1'b0;
        drop_d    = 1'b0;
        load_bank = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    // Element 0 seeds the running maximum straight from the
                    // input, so the scan only has to visit elements 1..N-1.
                    load_bank = 1'b1;
                    cur_max_d = in_elem[0];
                    cur_idx_d = '0;
                    cnt_d     = IDX_WIDTH'(1);
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                drop_d    = valid;
                cur_max_d = nxt_max;
                cur_idx_d = nxt_idx;
                cnt_d     = cnt_q + IDX_WIDTH'(1);
                if (cnt_q == LAST_IDX) begin
                    class_d = nxt_idx;
                    max_d   = nxt_max;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cur_max_q <= '0;
            cur_idx_q <= '0;
            class_q   <= '0;
            max_q     <= '0;
            ready_q   <= 1'b0;
            drop_q    <= 1'b0;
            for (int k = 0; k < N; k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_max_q <= cur_max_d;
            cur_idx_q <= cur_idx_d;
            class_q   <= class_d;
            max_q     <= max_d;
            ready_q   <= ready_d;
            drop_q    <= drop_d;
            if (load_bank) begin
                for (int k = 0; k < N; k++) begin
                    bank_q[k] <= in_elem[k];
                end
            end
        end
    end

    assign ready     = ready_q;
    assign class_out = class_q;
    assign max_out   = max_q;
    assign busy      = (state_q == ST_SCAN);
    assign drop      = drop_q;

endmodule

// File: doc/layer2_argmax_10x28.md
Name: layer2_argmax_10x28

Overview:
- Consumes the 10 packed class scores produced by the 121x16x10 output layer of the MNIST TCB net and reduces them to a predicted digit.
- Captures the 280-bit score vector on `valid`, then serially scans it with one signed comparator, one element per cycle.
- Emits the winning index and its score with a one-cycle `ready` pulse.
- Sits directly downstream of the output layer; its `valid` input is that layer's `ready`.

Parameters:
- N, 10, number of class scores.
- DATA_WIDTH, 28, width of each score (two's complement).
- IDX_WIDTH, 4, width of the class index; must satisfy 2^IDX_WIDTH >= N.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid  input  1  score vector on layer_in is valid this cycle.
- layer_in  input  N*DATA_WIDTH (280)  packed scores; element k occupies bits [k*28+27 : k*28].
- ready  output  1  one-cycle pulse; class_out and max_out are valid while it is high.
- class_out  output  IDX_WIDTH  index of the maximum score; held until the next result.
- max_out  output  DATA_WIDTH  maximum score, signed; held until the next result.
- busy  output  1  high while a scan is in progress.
- drop  output  1  one-cycle pulse when a valid is ignored because the block is busy.

Behaviour:
- Reset: asynchronous and active-high. While rst is high, every output and all internal state are 0 and the state is IDLE. An in-flight scan is abandoned without producing a ready pulse.
- States: IDLE and SCAN.
- IDLE:
  - On a rising edge with valid=1, register all N elements into a local bank.
  - Load cur_max with element 0, cur_idx with 0 and cnt with 1.
  - Set busy=1 and move to SCAN.
  - With valid=0, stay in IDLE.
- SCAN, each edge:
  - Compare elem[cnt] against cur_max as signed values.
  - If strictly greater, load cur_max and cur_idx with that element and cnt.
  - Ties keep the lower index.
  - Increment cnt.
- SCAN termination, on the edge where cnt == N-1:
  - Perform the final compare.
  - Register the post-compare winner into class_out and max_out.
  - Set ready=1, busy=0 and return to IDLE.
- Latency: the capture edge is E0. The element 1..9 compares occur on edges E1..E9. ready is high for exactly the cycle after E9 and deasserts on E10. A new valid is accepted from E10 onward, so the throughput is one vector per 10 cycles.
- Valid while busy: the input is ignored and the bank is unchanged. drop is high for one cycle after that edge. This includes valid coincident with the terminating edge E9.
- ready and drop are registered pulses and are never high for more than one consecutive cycle per event.
- class_out and max_out change only on a terminating edge or on reset.
- Arithmetic: all comparisons are signed at DATA_WIDTH. There is no saturation and no widening, because the upstream values are already wrapped at 28 bits.
- Boundaries:
  - All elements equal: class_out=0.
  - Maximum at index 9: found on the last compare.
  - Most negative value 0x8000000 is handled as the minimum.
  - rst asserted mid-SCAN returns to IDLE; the next valid after release starts a fresh scan.

Decomposition:
- Shared package `tcb_net_pkg`:
  - Constants N_CLASS=10, SCORE_W=28, IDX_W=4.
  - Score type as a signed DATA_WIDTH vector.
- One natural sub-module: `signed_max_cmp`, a combinational signed greater-than with index mux, returning the next cur_max and cur_idx.
- Unpacking layer_in and the FSM stay in the top module.

Test Plan:
- Reset then idle: rst pulse with no valid → all outputs 0 indefinitely; busy=0, ready never pulses.
- Single vector, scores 0..9 with element k = k*100 → ready pulse 10 cycles after the valid edge, class_out=9, max_out=900; busy high for exactly 9 cycles.
- Negative and tie handling, scores = {-59,-59,…} with element 3 = element 7 = 5 → class_out=3, max_out=5. Then all scores = 0x8000000 → class_out=0, max_out=0x8000000.
- Busy collision: valid at E0 (max at index 2, value 1234), valid again at E4 and at E9 → two drop pulses; result class_out=2 and max_out=1234 are unaffected.
- Back-to-back: a second valid at E10 with max at index 6, value -1 (others -1000) → first ready carries the first result, second ready 10 cycles later with class_out=6, max_out=0xFFFFFFF.
- Reset mid-scan: rst asserted at E5 → ready never pulses for that vector and outputs return to 0. A fresh valid after release gives a correct result with the standard 10-cycle latency.
